// File: rtl/wb_mem_arbiter_2m_if.sv
// Wishbone B4 point-to-point bundle. The master modport drives the request;
// the slave modport returns read data and the response.
interface wb_mem_arbiter_2m_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;
   logic [DW-1:0]   dat_r;
   logic [DW/8-1:0] sel;
   logic            we;
   logic            cyc;
   logic            stb;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic            ack;
   logic            err;
   logic            rty;

   modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte,
                   input  dat_r, ack, err, rty);
   modport slave  (input  adr, dat_w, sel, we, cyc, stb, cti, bte,
                   output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_mem_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC, with a
// per-beat ack watchdog that converts a hung slave into ERR to the granted master.
module wb_mem_arbiter_2m #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
)(
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n,
   wb_mem_arbiter_2m_if.slave   m0,
   wb_mem_arbiter_2m_if.slave   m1,
   wb_mem_arbiter_2m_if.master  s,
   output logic [1:0]           gnt_o
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] G0   = 2'd1;
   localparam logic [1:0] G1   = 2'd2;

   logic [1:0] state, nxt;
   logic       last;      // 0: M0 held the bus most recently, 1: M1
   logic       g0, g1;
   logic       gstb, resp, abort;
   logic       err, ack, rty;

   assign g0    = (state == G0);
   assign g1    = (state == G1);
   assign gnt_o = {g1, g0};

   always_comb begin
      nxt = state;
      case (state)
         G0: if (!m0.cyc) nxt = m1.cyc ? G1 : IDLE;
         G1: if (!m1.cyc) nxt = m0.cyc ? G0 : IDLE;
         default: begin
            if (m0.cyc && m1.cyc) nxt = last ? G0 : G1;
            else if (m0.cyc)      nxt = G0;
            else if (m1.cyc)      nxt = G1;
            else                  nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= nxt;
         if (nxt == G0)      last <= 1'b0;
         else if (nxt == G1) last <= 1'b1;
      end
   end

   assign s.adr   = g0 ? m0.adr   : g1 ? m1.adr   : {AW{1'b0}};
   assign s.dat_w = g0 ? m0.dat_w : g1 ? m1.dat_w : {DW{1'b0}};
   assign s.sel   = g0 ? m0.sel   : g1 ? m1.sel   : {(DW/8){1'b0}};
   assign s.we    = (g0 & m0.we)  | (g1 & m1.we);
   assign s.cyc   = (g0 & m0.cyc) | (g1 & m1.cyc);
   assign s.cti   = g0 ? m0.cti   : g1 ? m1.cti   : 3'b000;
   assign s.bte   = g0 ? m0.bte   : g1 ? m1.bte   : 2'b00;
   assign s.stb   = gstb & !abort;

   assign gstb = (g0 & m0.stb) | (g1 & m1.stb);
   assign resp = s.ack | s.err | s.rty;

   generate
      if (TIMEOUT > 0) begin : g_wdog
         localparam int WW = $clog2(TIMEOUT + 1);
         logic [WW-1:0] wdog;

         // A late ack on the expiry cycle still completes the beat normally.
         assign abort = gstb && (wdog == WW'(TIMEOUT)) && !s.ack;

         always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
            if (!wb_rst_n)                  wdog <= '0;
            else if (!gstb || resp || abort) wdog <= '0;
            else if (wdog != WW'(TIMEOUT))  wdog <= wdog + 1'b1;
         end
      end else begin : g_no_wdog
         assign abort = 1'b0;
      end
   endgenerate

   // A misbehaving slave may raise several responses at once; pass only one.
   assign err = s.err | abort;
   assign ack = s.ack & !err;
   assign rty = s.rty & !err & !s.ack;

   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;
   assign m0.ack   = g0 & m0.cyc & ack;
   assign m0.err   = g0 & m0.cyc & err;
   assign m0.rty   = g0 & m0.cyc & rty;
   assign m1.ack   = g1 & m1.cyc & ack;
   assign m1.err   = g1 & m1.cyc & err;
   assign m1.rty   = g1 & m1.cyc & rty;
endmodule

// File: tb/tb_wb_mem_arbiter_2m.sv
// Directed bench: vector table for arbitration/response routing, plus hand
// sequences for reset, an 8-beat burst and the watchdog.
module tb_wb_mem_arbiter_2m;
   logic       clk;
   logic       rst_n;
   logic [1:0] gnt;
   int         total = 0;
   int         bad   = 0;

   wb_mem_arbiter_2m_if #(.AW(32), .DW(32)) m0_if ();
   wb_mem_arbiter_2m_if #(.AW(32), .DW(32)) m1_if ();
   wb_mem_arbiter_2m_if #(.AW(32), .DW(32)) s_if ();

   wb_mem_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .m0       (m0_if),
      .m1       (m1_if),
      .s        (s_if),
      .gnt_o    (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;   // {cyc0, stb0, cyc1, stb1}
      logic [2:0] rsp;   // slave {ack, err, rty}
      logic [1:0] gnt;
      logic [1:0] cs;    // {s_cyc, s_stb}
      logic [2:0] r0;    // M0 {ack, err, rty}
      logic [2:0] r1;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      logic        e_we;
      logic [2:0]  cti;
      int first, second, pulses, stb_at_err, gap;

      tbl[0]  = '{4'b0000, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000};
      tbl[1]  = '{4'b1111, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000};
      tbl[2]  = '{4'b1111, 3'b100, 2'b01, 2'b11, 3'b100, 3'b000};
      tbl[3]  = '{4'b0011, 3'b100, 2'b01, 2'b00, 3'b000, 3'b000};
      tbl[4]  = '{4'b1111, 3'b100, 2'b10, 2'b11, 3'b000, 3'b100};
      tbl[5]  = '{4'b1100, 3'b000, 2'b10, 2'b00, 3'b000, 3'b000};
      tbl[6]  = '{4'b1111, 3'b100, 2'b01, 2'b11, 3'b100, 3'b000};
      tbl[7]  = '{4'b0011, 3'b000, 2'b01, 2'b00, 3'b000, 3'b000};
      tbl[8]  = '{4'b1111, 3'b111, 2'b10, 2'b11, 3'b000, 3'b010};
      tbl[9]  = '{4'b1111, 3'b001, 2'b10, 2'b11, 3'b000, 3'b001};
      tbl[10] = '{4'b1111, 3'b101, 2'b10, 2'b11, 3'b000, 3'b100};
      tbl[11] = '{4'b1100, 3'b000, 2'b10, 2'b00, 3'b000, 3'b000};
      tbl[12] = '{4'b1000, 3'b000, 2'b01, 2'b10, 3'b000, 3'b000};
      tbl[13] = '{4'b1100, 3'b100, 2'b01, 2'b11, 3'b100, 3'b000};
      tbl[14] = '{4'b0000, 3'b000, 2'b01, 2'b00, 3'b000, 3'b000};
      tbl[15] = '{4'b0000, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000};
      tbl[16] = '{4'b0011, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000};
      tbl[17] = '{4'b0011, 3'b100, 2'b10, 2'b11, 3'b000, 3'b100};
      tbl[18] = '{4'b0000, 3'b000, 2'b10, 2'b00, 3'b000, 3'b000};
      tbl[19] = '{4'b0000, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000};

      // reset held with M0 requesting and the slave acking
      rst_n = 1'b0;
      m0_if.adr = 32'h1000; m0_if.dat_w = 32'h0000_AAAA; m0_if.sel = 4'hF; m0_if.we = 1'b1;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.cti = 3'b000; m0_if.bte = 2'b00;
      m1_if.adr = 32'h2000; m1_if.dat_w = 32'h0000_BBBB; m1_if.sel = 4'h3; m1_if.we = 1'b0;
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = 3'b000; m1_if.bte = 2'b00;
      s_if.dat_r = 32'h0; s_if.ack = 1'b1; s_if.err = 1'b0; s_if.rty = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst gnt",    32'(gnt), 32'h0);
      chk("rst s_cyc",  32'(s_if.cyc), 32'h0);
      chk("rst s_stb",  32'(s_if.stb), 32'h0);
      chk("rst s_adr",  s_if.adr, 32'h0);
      chk("rst m0_ack", 32'(m0_if.ack), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         {m0_if.cyc, m0_if.stb, m1_if.cyc, m1_if.stb} = tbl[i].req;
         {s_if.ack, s_if.err, s_if.rty} = tbl[i].rsp;
         s_if.dat_r = 32'hD000_0000 + 32'(i);
         #1;
         e_adr = (tbl[i].gnt == 2'b01) ? 32'h1000      : (tbl[i].gnt == 2'b10) ? 32'h2000      : 32'h0;
         e_dat = (tbl[i].gnt == 2'b01) ? 32'h0000_AAAA : (tbl[i].gnt == 2'b10) ? 32'h0000_BBBB : 32'h0;
         e_sel = (tbl[i].gnt == 2'b01) ? 4'hF          : (tbl[i].gnt == 2'b10) ? 4'h3          : 4'h0;
         e_we  = (tbl[i].gnt == 2'b01);
         chk($sformatf("v%0d gnt", i),     32'(gnt), 32'(tbl[i].gnt));
         chk($sformatf("v%0d cyc_stb", i), 32'({s_if.cyc, s_if.stb}), 32'(tbl[i].cs));
         chk($sformatf("v%0d s_adr", i),   s_if.adr, e_adr);
         chk($sformatf("v%0d s_dat", i),   s_if.dat_w, e_dat);
         chk($sformatf("v%0d s_sel", i),   32'(s_if.sel), 32'(e_sel));
         chk($sformatf("v%0d s_we", i),    32'(s_if.we), 32'(e_we));
         chk($sformatf("v%0d m0_rsp", i),  32'({m0_if.ack, m0_if.err, m0_if.rty}), 32'(tbl[i].r0));
         chk($sformatf("v%0d m1_rsp", i),  32'({m1_if.ack, m1_if.err, m1_if.rty}), 32'(tbl[i].r1));
         chk($sformatf("v%0d m0_dat", i),  m0_if.dat_r, 32'hD000_0000 + 32'(i));
         chk($sformatf("v%0d m1_dat", i),  m1_if.dat_r, 32'hD000_0000 + 32'(i));
      end

      // 8-beat burst on M1 while M0 waits; grant only moves after M1 drops CYC
      @(negedge clk);
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.cti = 3'b010; m1_if.bte = 2'b01;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         cti = (b == 7) ? 3'b111 : 3'b010;
         m1_if.cti = cti;
         m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
         s_if.ack = 1'b1;
         #1;
         chk($sformatf("burst%0d gnt", b),    32'(gnt), 32'h2);
         chk($sformatf("burst%0d m1_ack", b), 32'(m1_if.ack), 32'h1);
         chk($sformatf("burst%0d m0_ack", b), 32'(m0_if.ack), 32'h0);
         chk($sformatf("burst%0d s_cti", b),  32'(s_if.cti), 32'(cti));
         chk($sformatf("burst%0d s_bte", b),  32'(s_if.bte), 32'h1);
      end
      @(negedge clk);
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = 3'b000; m1_if.bte = 2'b00; s_if.ack = 1'b0;
      #1;
      chk("burst tail gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      s_if.ack = 1'b1;
      #1;
      chk("burst handoff gnt", 32'(gnt), 32'h1);
      chk("burst handoff adr", s_if.adr, 32'h1000);
      chk("burst handoff ack", 32'(m0_if.ack), 32'h1);
      @(negedge clk);
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("idle before wdog", 32'(gnt), 32'h0);

      // watchdog: slave never answers M0
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      first = -1; second = -1; pulses = 0; stb_at_err = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         if (m0_if.err) begin
            pulses++;
            if (first < 0) begin
               first = n;
               stb_at_err = int'(s_if.stb);
            end else if (second < 0) second = n;
         end
      end
      chk("wdog first err",   32'(first), 32'd16);
      chk("wdog s_stb at err", 32'(stb_at_err), 32'd0);
      chk("wdog second err",  32'(second), 32'd33);
      chk("wdog pulse count", 32'(pulses), 32'd2);
      chk("wdog gnt kept",    32'(gnt), 32'h1);

      // ack landing exactly on the expiry cycle wins over the abort
      @(negedge clk);
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      @(negedge clk);
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      for (int n = 0; n <= 16; n++) begin
         @(negedge clk);
         if (n == 16) s_if.ack = 1'b1;
         #1;
      end
      chk("late ack m0_ack", 32'(m0_if.ack), 32'h1);
      chk("late ack m0_err", 32'(m0_if.err), 32'h0);
      chk("late ack s_stb",  32'(s_if.stb), 32'h1);
      @(negedge clk);
      s_if.ack = 1'b0;
      gap = -1;
      for (int n = 0; n < 40 && gap < 0; n++) begin
         #1;
         if (m0_if.err) gap = n;
         else @(negedge clk);
      end
      chk("wdog restart after ack", 32'(gap), 32'd16);

      // asynchronous reset in the middle of a granted cycle
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst gnt",   32'(gnt), 32'h0);
      chk("async rst s_cyc", 32'(s_if.cyc), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
